// File: rtl/quad_shift_sequencer.sv
// quad_shift_sequencer: control for the 4-quarter wide-to-narrow operand shift register.
// Optional macro SHIFT_SEQ_MASK_SKIP_EN compiles in skipping of all-zero mask quarters.
module quad_shift_sequencer #(
  parameter int QUARTER_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [4*QUARTER_W-1:0] in_mask,
  output logic                   in_ready,
  output logic                   sh_wr_en,
  output logic                   sh_shift_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_qidx,
  output logic                   out_last,
  output logic                   done,
  output logic                   busy
);

  localparam int MW = 4 * QUARTER_W;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [1:0]      qidx;
  logic [1:0]      qidx_nx;
  logic [MW-1:0]   mask_q;
  logic [MW-1:0]   mask_nx;

  // cur_nz: current quarter is to be presented
  // later_nz: some quarter after qidx is still to be presented
  // in_any: the offered operand has at least one quarter to present
  logic            cur_nz;
  logic            later_nz;
  logic            in_any;

`ifdef SHIFT_SEQ_MASK_SKIP_EN
  logic [3:0]      q_nz;

  // Per-quarter "has active lanes" flags of the captured mask
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      q_nz[i] = |mask_q[i*QUARTER_W +: QUARTER_W];
    end
  end

  // Look ahead for any active quarter beyond the current one
  always_comb begin
    later_nz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > int'(qidx) && q_nz[i]) begin
        later_nz = 1'b1;
      end
    end
  end

  assign cur_nz = q_nz[qidx];
  assign in_any = |in_mask;
`else
  // Mask is captured for downstream visibility only; all quarters run
  logic unused_mask;
  assign unused_mask = ^mask_q;
  assign cur_nz      = 1'b1;
  assign later_nz    = (qidx != 2'd3);
  assign in_any      = 1'b1;
`endif

  logic present;
  logic last;
  logic accept;
  logic skip;
  logic retire;
  logic reload;

  assign present = (state == DRAIN) && cur_nz;
  assign last    = (qidx == 2'd3) || !later_nz;
  assign accept  = present && out_ready;
  assign skip    = (state == DRAIN) && !cur_nz;
  assign retire  = accept && last;
  // A zero-mask offer is never chained behind a retiring operand: it
  // waits one cycle and retires from IDLE so it gets its own done pulse.
  assign reload  = retire && in_valid && in_any;

  // State register: sequencer state, quarter index and captured mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      qidx   <= 2'd0;
      mask_q <= '0;
    end else begin
      state  <= state_nx;
      qidx   <= qidx_nx;
      mask_q <= mask_nx;
    end
  end

  // Next-state logic: load, advance, skip, retire or chain a new operand
  always_comb begin
    state_nx = state;
    qidx_nx  = qidx;
    mask_nx  = mask_q;
    unique case (state)
      IDLE: begin
        if (in_valid && in_any) begin
          state_nx = DRAIN;
          qidx_nx  = 2'd0;
          mask_nx  = in_mask;
        end
      end
      DRAIN: begin
        if (skip) begin
          qidx_nx = qidx + 2'd1;
        end else if (accept && !last) begin
          qidx_nx = qidx + 2'd1;
        end else if (reload) begin
          qidx_nx = 2'd0;
          mask_nx = in_mask;
        end else if (retire) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Output logic: handshakes and shift-register strobes
  always_comb begin
    in_ready    = 1'b0;
    sh_wr_en    = 1'b0;
    sh_shift_en = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !rst;
        sh_wr_en = !rst && in_valid && in_any;
        done     = !rst && in_valid && !in_any;
      end
      DRAIN: begin
        in_ready    = !rst && retire && in_any;
        sh_wr_en    = !rst && reload;
        sh_shift_en = skip || (accept && !last);
        done        = !rst && retire;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign out_valid = present;
  assign out_qidx  = qidx;
  assign out_last  = present && last;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_quad_shift_sequencer.sv
// tb_quad_shift_sequencer: scoreboard bench for quad_shift_sequencer.
// Honours SHIFT_SEQ_MASK_SKIP_EN the same way the design does.
module tb_quad_shift_sequencer;

  localparam int QW = 16;
  localparam int MW = 4 * QW;
`ifdef SHIFT_SEQ_MASK_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [MW-1:0] in_mask = '0;
  logic          in_ready;
  logic          sh_wr_en;
  logic          sh_shift_en;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_qidx;
  logic          out_last;
  logic          done;
  logic          busy;

  quad_shift_sequencer #(.QUARTER_W(QW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_mask(in_mask),
    .in_ready(in_ready),
    .sh_wr_en(sh_wr_en),
    .sh_shift_en(sh_shift_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_qidx(out_qidx),
    .out_last(out_last),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]    q;
    logic          last;
    logic [QW-1:0] d;
  } exp_t;

  exp_t          sbq[$];
  logic [MW-1:0] din = '0;
  logic [MW-1:0] shreg = '0;
  bit            mon_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Expected presentation list for one operand: every quarter, or only
  // the quarters with active lanes when skipping is compiled in.
  function automatic void expect_op(logic [MW-1:0] m, logic [MW-1:0] d);
    int keep[$];
    for (int q = 0; q < 4; q++) begin
      if (!SKIP || m[q*QW +: QW] != '0) keep.push_back(q);
    end
    foreach (keep[k]) begin
      sbq.push_back('{q: 2'(keep[k]),
                      last: (k == keep.size() - 1),
                      d: d[keep[k]*QW +: QW]});
    end
  endfunction

  function automatic logic [MW-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [MW-1:0] rand_mask();
    logic [MW-1:0] m;
    m = '0;
    case ($urandom_range(0, 4))
      0: m = '0;
      1: m = '1;
      2: m = rand64();
      default: begin
        for (int q = 0; q < 4; q++) begin
          m[q*QW +: QW] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0;
        end
      end
    endcase
    return m;
  endfunction

  // Behavioural shift register driven by the DUT strobes
  always @(posedge clk) begin
    if (sh_wr_en) shreg <= din;
    else if (sh_shift_en) shreg <= shreg >> QW;
  end

  // Stimulus side of the scoreboard: push on every accepted operand
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) expect_op(in_mask, din);
  end

  // Monitor: compare every presented quarter and the handshake rules
  always @(negedge clk) begin
    logic exp_done;
    exp_t e;
    if (mon_en && !rst) begin
      exp_done = SKIP && in_valid && in_ready && (in_mask == '0);
      chk("strobe_overlap", 64'(sh_wr_en & sh_shift_en), 64'd0);
      chk("wr_en", 64'(sh_wr_en),
          64'(in_valid && in_ready && (!SKIP || in_mask != '0)));
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_quarter qidx=%0d required=none", out_qidx);
        end else begin
          e = sbq[0];
          chk("qidx", 64'(out_qidx), 64'(e.q));
          chk("last", 64'(out_last), 64'(e.last));
          chk("data", 64'(shreg[QW-1:0]), 64'(e.d));
          if (out_ready) begin
            void'(sbq.pop_front());
            if (e.last) exp_done = 1'b1;
          end else begin
            chk("stall_quiet", {61'd0, sh_wr_en, sh_shift_en, in_ready}, 64'd0);
          end
        end
      end
      chk("done", 64'(done), 64'(exp_done));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int max);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (busy && n < max) begin
      step();
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL drain_timeout busy=%0b required=0", busy);
    end
    step();
  endtask

  task automatic count_quarters(int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) cnt++;
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int loads;
    int cnt;
    bit hs;

    // Reset state, with an operand already offered
    in_valid = 1'b1;
    in_mask  = '1;
    din      = rand64();
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_outs", {57'd0, sh_wr_en, sh_shift_en, out_valid,
                     out_qidx, out_last, done, busy}, 64'd0);
    step();
    rst = 1'b0;
    mon_en = 1'b1;

    // Single full operand, consumer always ready
    @(negedge clk);
    chk("t1_wr", 64'(sh_wr_en), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_qidx", 64'(out_qidx), 64'(i));
      chk("t1_shift", 64'(sh_shift_en), 64'(i < 3));
      chk("t1_last", 64'(out_last), 64'(i == 3));
      chk("t1_done", 64'(done), 64'(i == 3));
      chk("t1_in_ready", 64'(in_ready), 64'(i == 3));
      step();
    end
    @(negedge clk);
    chk("t1_idle", 64'(busy), 64'd0);
    step();

    // Two operands back to back, no bubble
    in_valid = 1'b1;
    in_mask  = '1;
    din      = rand64();
    @(negedge clk);
    loads = (in_valid && in_ready) ? 1 : 0;
    step();
    din = rand64();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_qidx", 64'(out_qidx), 64'(i % 4));
      chk("t2_wr", 64'(sh_wr_en), 64'(i == 3));
      chk("t2_done", 64'(done), 64'(i % 4 == 3));
      if (in_valid && in_ready) loads++;
      step();
      if (loads == 2) in_valid = 1'b0;
    end
    chk("t2_loads", 64'(loads), 64'd2);
    drain(10);

    // Consumer stall at quarter 1
    in_valid = 1'b1;
    in_mask  = '1;
    din      = rand64();
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_qidx", 64'(out_qidx), 64'd1);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_no_strobe", {62'd0, sh_wr_en, sh_shift_en}, 64'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_resume", 64'(out_qidx), 64'd1);
    chk("t3_resume_shift", 64'(sh_shift_en), 64'd1);
    drain(10);

    // Asynchronous reset in the middle of an operand
    in_valid = 1'b1;
    in_mask  = '1;
    din      = rand64();
    step();
    in_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t4_at_q2", 64'(out_qidx), 64'd2);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("t4_async_zero", {56'd0, in_ready, sh_wr_en, sh_shift_en, out_valid,
                          out_qidx, out_last, done, busy}, 64'd0);
    step();
    sbq.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    chk("t4_no_done", 64'(done), 64'd0);
    mon_en = 1'b1;
    step();

    // Mask with holes: quarters 1 and 3 empty
    in_valid = 1'b1;
    in_mask  = 64'h0000_FFFF_0000_FFFF;
    din      = rand64();
`ifdef SHIFT_SEQ_MASK_SKIP_EN
    @(negedge clk);
    chk("t5_wr", 64'(sh_wr_en), 64'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_q0", {61'd0, out_valid, out_qidx}, {61'd0, 1'b1, 2'd0});
    chk("t5_q0_shift", {62'd0, sh_shift_en, out_last}, {62'd0, 1'b1, 1'b0});
    step();
    @(negedge clk);
    chk("t5_bubble", {61'd0, out_valid, out_qidx}, {61'd0, 1'b0, 2'd1});
    chk("t5_bubble_shift", 64'(sh_shift_en), 64'd1);
    step();
    @(negedge clk);
    chk("t5_q2", {61'd0, out_valid, out_qidx}, {61'd0, 1'b1, 2'd2});
    chk("t5_q2_end", {61'd0, out_last, done, sh_shift_en}, {61'd0, 1'b1, 1'b1, 1'b0});
    step();
    @(negedge clk);
    chk("t5_idle", {62'd0, busy, sh_shift_en}, 64'd0);
    step();
`else
    step();
    in_valid = 1'b0;
    count_quarters(6, cnt);
    chk("t5_all_quarters", 64'(cnt), 64'd4);
`endif

    // All-zero mask offered in IDLE
    in_valid = 1'b1;
    in_mask  = '0;
    din      = rand64();
`ifdef SHIFT_SEQ_MASK_SKIP_EN
    @(negedge clk);
    chk("t6_zero", {61'd0, in_ready, done, sh_wr_en}, {61'd0, 1'b1, 1'b1, 1'b0});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd0);
    step();
`else
    step();
    in_valid = 1'b0;
    count_quarters(6, cnt);
    chk("t6_zero_quarters", 64'(cnt), 64'd4);
`endif
    drain(10);

    // Randomised traffic with random consumer back-pressure
    for (int c = 0; c < 2000; c++) begin
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_mask  = rand_mask();
        din      = rand64();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs = in_valid && in_ready;
      step();
      if (hs) in_valid = 1'b0;
    end
    drain(50);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
